dcache_mem_port: RTL and testbench
==================================

// Module: dcache_mem_port
// PURPOSE
// - Initiator side of the main-memory interface for the data cache. Converts one cache-line refill or writeback into
//   LINE_WORDS sequential 4-byte MEM_READ/MEM_WRITE beats and reassembles refill data.
// - Sits between the data cache controller and main memory, driving the d-cache request signal, address, data and data type.
// - Retries any beat that main memory did not complete for the data side.
// PARAMETERS
// - ADDR_WIDTH       17  byte address width of main memory
// - DATA_LEN         32  memory beat width in bits
// - BYTE_SIZE        8   bits per byte
// - LINE_WORDS       4   beats per cache line (line = LINE_WORDS*4 bytes)
// - WORD_INDEX_SIZE  2   log2(LINE_WORDS)
// - MAX_RETRY        15  retry limit per beat (used only with DMEM_RETRY_LIMIT_EN)
// PORTS
// - clk             in   1                      clock; all state updates on posedge
// - rst             in   1                      asynchronous, active-high reset
// - req_valid       in   1                      cache requests a line transfer
// - req_ready       out  1                      high in IDLE; request accepted when req_valid&&req_ready
// - req_write       in   1                      1 = writeback, 0 = refill
// - req_addr        in   ADDR_WIDTH             line base address; low WORD_INDEX_SIZE+2 bits forced to 0
// - req_wdata       in   LINE_WORDS*DATA_LEN    writeback line; word k in [k*DATA_LEN +: DATA_LEN]
// - resp_valid      out  1                      one-cycle pulse: transfer complete
// - resp_rdata      out  LINE_WORDS*DATA_LEN    refilled line, same word layout; valid with resp_valid
// - busy            out  1                      high in any state other than IDLE
// - mem_vis_signal  out  2                      MEM_NOP/MEM_READ/MEM_WRITE to main memory (d-cache side)
// - mem_vis_addr    out  ADDR_WIDTH             beat byte address
// - written_data    out  DATA_LEN               beat write word; memory byte order (lowest address in [31:24])
// - data_type       out  3                      always FOUR_BYTE while a beat is driven
// - mem_data        in   DATA_LEN               read word from memory, memory byte order
// - mem_status      in   2                      MEM_RESTING/MEM_DATA_FINISHED/MEM_INST_FINISHED
// - err             out  1                      present only with DMEM_RETRY_LIMIT_EN
// BEHAVIOUR
// - Reset values: state IDLE, mem_vis_signal MEM_NOP, mem_vis_addr 0, written_data 0, data_type 0, resp_valid 0,
//   resp_rdata 0, busy 0, beat 0, retry 0, err 0. Reset mid-transfer aborts immediately with no resp_valid.
//   Beats already written to memory are not rolled back.
// - FSM:
//   - IDLE: on accept, latch addr, write flag and wdata; beat <= 0; go to REQ.
//   - REQ: drive MEM_READ or MEM_WRITE, addr = base + 4*beat, data_type FOUR_BYTE, written_data = word[beat];
//     go to WAIT (1 cycle).
//   - WAIT: drive MEM_NOP. Memory result is valid now because memory registers its response.
//     - mem_status==MEM_DATA_FINISHED: on a read, capture mem_data into word[beat]. If beat==LINE_WORDS-1 go to DONE;
//       otherwise beat++, retry <= 0, go to REQ.
//     - any other status (MEM_INST_FINISHED: the i-cache was served; MEM_RESTING): retry++ and go to REQ with the
//       same beat.
//   - DONE: resp_valid=1 for exactly one cycle; go to IDLE. req_ready is 0 in DONE, so back-to-back requests
//     cost 1 idle cycle.
// - Latency with no retries: 2*LINE_WORDS+1 cycles from accept to resp_valid (9 cycles at default LINE_WORDS).
// - Address arithmetic is modulo 2^ADDR_WIDTH: a line at the top of memory wraps to 0.
// - req_valid while busy is ignored (not queued). Inputs are sampled only on accept.
// - resp_rdata holds its value until the next refill completes. A writeback leaves resp_rdata unchanged.
// CONFIGURATION
// - DMEM_RETRY_LIMIT_EN defined: when retry reaches MAX_RETRY in WAIT without MEM_DATA_FINISHED, assert err
//   (sticky until rst), go to DONE, and pulse resp_valid with partial data.
// - DMEM_RETRY_LIMIT_EN undefined: no err port; retries are unbounded.
// STRUCTURE
// - Shared defines.v: MEM_NOP/MEM_READ/MEM_WRITE, MEM_RESTING/MEM_DATA_FINISHED/MEM_INST_FINISHED,
//   ONE_BYTE..EIGHT_BYTE, plus the new FSM state encodings DMP_IDLE/DMP_REQ/DMP_WAIT/DMP_DONE.
// - One sub-module: dcache_line_buffer, a LINE_WORDS x DATA_LEN register file with parallel load, word write
//   enable and word-indexed read.
// TESTING
// - Refill at 0x00100 with memory bytes 00..0F: resp_valid at cycle 9; resp_rdata word0=0x00010203, word3=0x0C0D0E0F.
// - Writeback at 0x00200 with words 0xDEADBEEF,1,2,3: four MEM_WRITE beats at 0x200/204/208/20C with FOUR_BYTE;
//   readback refill matches.
// - Refill while the i-cache holds MEM_READ for beat 1: MEM_INST_FINISHED triggers a retry of beat 1 at the same address;
//   data is correct after the i-cache drops to NOP.
// - Refill at 0x1FFF0 wraps cleanly: the last beat address is 0x1FFFC, with no overflow into bit 17.
// - Assert rst during beat 2 of a writeback: mem_vis_signal is MEM_NOP and busy 0 immediately; no resp_valid;
//   the next request works.
// - With DMEM_RETRY_LIMIT_EN and the i-cache permanently reading: err=1 and resp_valid pulse after MAX_RETRY retries.

Source files
------------

// File: rtl/dcache_mem_port_pkg.sv
// Shared constants for the d-cache memory port: memory command/status codes,
// transfer sizes, FSM state encoding and beat address arithmetic.
package dcache_mem_port_pkg;

   localparam int ADDR_WIDTH      = 17;
   localparam int DATA_LEN        = 32;
   localparam int BYTE_SIZE       = 8;
   localparam int LINE_WORDS      = 4;
   localparam int WORD_INDEX_SIZE = 2;
   localparam int MAX_RETRY       = 15;

   localparam logic [1:0] MEM_NOP   = 2'd0;
   localparam logic [1:0] MEM_READ  = 2'd1;
   localparam logic [1:0] MEM_WRITE = 2'd2;

   localparam logic [1:0] MEM_RESTING       = 2'd0;
   localparam logic [1:0] MEM_DATA_FINISHED = 2'd1;
   localparam logic [1:0] MEM_INST_FINISHED = 2'd2;

   localparam logic [2:0] ONE_BYTE   = 3'd1;
   localparam logic [2:0] TWO_BYTE   = 3'd2;
   localparam logic [2:0] FOUR_BYTE  = 3'd3;
   localparam logic [2:0] EIGHT_BYTE = 3'd4;

   typedef enum logic [1:0] {
      DMP_IDLE = 2'd0,
      DMP_REQ  = 2'd1,
      DMP_WAIT = 2'd2,
      DMP_DONE = 2'd3
   } dmp_state_e;

   // Byte address of a beat; wraps modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0]      base,
                                                       input logic [WORD_INDEX_SIZE-1:0] beat);
      return base + ADDR_WIDTH'({beat, 2'b00});
   endfunction

endpackage

// File: rtl/dcache_mem_port_if.sv
// Bundle of cache-side request/response and memory-side beat signals.
// The err signal exists only when DMEM_RETRY_LIMIT_EN is defined.
interface dcache_mem_port_if;
   import dcache_mem_port_pkg::*;

   logic                           req_valid;
   logic                           req_ready;
   logic                           req_write;
   logic [ADDR_WIDTH-1:0]          req_addr;
   logic [LINE_WORDS*DATA_LEN-1:0] req_wdata;
   logic                           resp_valid;
   logic [LINE_WORDS*DATA_LEN-1:0] resp_rdata;
   logic                           busy;
   logic [1:0]                     mem_vis_signal;
   logic [ADDR_WIDTH-1:0]          mem_vis_addr;
   logic [DATA_LEN-1:0]            written_data;
   logic [2:0]                     data_type;
   logic [DATA_LEN-1:0]            mem_data;
   logic [1:0]                     mem_status;
`ifdef DMEM_RETRY_LIMIT_EN
   logic                           err;
`endif

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_data, mem_status,
      output req_ready, resp_valid, resp_rdata, busy,
             mem_vis_signal, mem_vis_addr, written_data, data_type
`ifdef DMEM_RETRY_LIMIT_EN
      , output err
`endif
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_data, mem_status,
      input  req_ready, resp_valid, resp_rdata, busy,
             mem_vis_signal, mem_vis_addr, written_data, data_type
`ifdef DMEM_RETRY_LIMIT_EN
      , input err
`endif
   );

endinterface

// File: rtl/dcache_line_buffer.sv
// One cache line of words: parallel load of a whole line, single-word write,
// word-indexed read and a flat view of the whole line.
module dcache_line_buffer
   import dcache_mem_port_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_i,
   input  logic [LINE_WORDS*DATA_LEN-1:0] load_data_i,
   input  logic                           wr_en_i,
   input  logic [WORD_INDEX_SIZE-1:0]     wr_idx_i,
   input  logic [DATA_LEN-1:0]            wr_data_i,
   input  logic [WORD_INDEX_SIZE-1:0]     rd_idx_i,
   output logic [DATA_LEN-1:0]            rd_data_o,
   output logic [LINE_WORDS*DATA_LEN-1:0] line_o
);

   logic [LINE_WORDS-1:0][DATA_LEN-1:0] word_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
      end else if (load_i) begin
         word_q <= load_data_i;
      end else if (wr_en_i) begin
         word_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = word_q[rd_idx_i];
   assign line_o    = word_q;

endmodule

// File: rtl/dcache_mem_port.sv
// Splits a d-cache line refill/writeback into LINE_WORDS four-byte memory beats,
// retrying beats memory did not serve. DMEM_RETRY_LIMIT_EN bounds retries and adds err.
module dcache_mem_port
   import dcache_mem_port_pkg::*;
(
   input logic              clk,
   input logic              rst,
   dcache_mem_port_if.slave bus
);

   localparam int LINE_BITS = LINE_WORDS * DATA_LEN;
   localparam int OFF_BITS  = WORD_INDEX_SIZE + 2;

   dmp_state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]      base_q;
   logic                       write_q;
   logic [WORD_INDEX_SIZE-1:0] beat_q, beat_d;
   logic [LINE_BITS-1:0]       rdata_q, rdata_d;
   logic [LINE_BITS-1:0]       line;
   logic [LINE_BITS-1:0]       merged;
   logic [DATA_LEN-1:0]        beat_word;
   logic                       accept;
   logic                       in_wait;
   logic                       mem_done;
   logic                       last_beat;
   logic                       give_up;
   logic                       unused_addr_bits;

   assign accept    = (state_q == DMP_IDLE) && bus.req_valid;
   assign in_wait   = (state_q == DMP_WAIT);
   assign mem_done  = (bus.mem_status == MEM_DATA_FINISHED);
   assign last_beat = (beat_q == WORD_INDEX_SIZE'(LINE_WORDS - 1));
   assign unused_addr_bits = ^bus.req_addr[OFF_BITS-1:0];

`ifdef DMEM_RETRY_LIMIT_EN
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_q;
   logic               err_q;

   assign give_up = in_wait && !mem_done && (retry_q == RETRY_W'(MAX_RETRY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retry_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept || (in_wait && mem_done)) begin
            retry_q <= '0;
         end else if (in_wait) begin
            retry_q <= retry_q + RETRY_W'(1);
         end
         if (give_up) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign give_up = 1'b0;
`endif

   // Refills start from a zeroed line so an aborted refill never exposes stale writeback data.
   dcache_line_buffer u_line_buffer (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .load_data_i (bus.req_write ? bus.req_wdata : '0),
      .wr_en_i     (in_wait && mem_done && !write_q),
      .wr_idx_i    (beat_q),
      .wr_data_i   (bus.mem_data),
      .rd_idx_i    (beat_q),
      .rd_data_o   (beat_word),
      .line_o      (line)
   );

   // The final beat lands in the buffer on the same edge resp_rdata is loaded, so splice it in here.
   generate
      for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_merge
         assign merged[gi*DATA_LEN +: DATA_LEN] =
            (mem_done && (beat_q == WORD_INDEX_SIZE'(gi))) ? bus.mem_data
                                                            : line[gi*DATA_LEN +: DATA_LEN];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DMP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DMP_IDLE: if (accept) state_d = DMP_REQ;
         DMP_REQ:  state_d = DMP_WAIT;
         DMP_WAIT: begin
            if (mem_done) begin
               state_d = last_beat ? DMP_DONE : DMP_REQ;
            end else if (give_up) begin
               state_d = DMP_DONE;
            end else begin
               state_d = DMP_REQ;
            end
         end
         DMP_DONE: state_d = DMP_IDLE;
         default:  state_d = DMP_IDLE;
      endcase
   end

   always_comb begin
      beat_d = beat_q;
      if (accept) begin
         beat_d = '0;
      end else if (in_wait && mem_done && !last_beat) begin
         beat_d = beat_q + WORD_INDEX_SIZE'(1);
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (in_wait && (state_d == DMP_DONE) && !write_q) begin
         rdata_d = merged;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q  <= '0;
         write_q <= 1'b0;
         beat_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            base_q  <= {bus.req_addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
            write_q <= bus.req_write;
         end
         beat_q  <= beat_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      bus.req_ready      = (state_q == DMP_IDLE);
      bus.busy           = (state_q != DMP_IDLE);
      bus.resp_valid     = (state_q == DMP_DONE);
      bus.resp_rdata     = rdata_q;
      bus.mem_vis_signal = MEM_NOP;
      bus.mem_vis_addr   = '0;
      bus.written_data   = '0;
      bus.data_type      = '0;
      if (state_q == DMP_REQ) begin
         bus.mem_vis_signal = write_q ? MEM_WRITE : MEM_READ;
         bus.mem_vis_addr   = beat_addr(base_q, beat_q);
         bus.written_data   = write_q ? beat_word : '0;
         bus.data_type      = FOUR_BYTE;
      end
   end

endmodule

// File: tb/tb_dcache_mem_port.sv
// Randomized bench for dcache_mem_port against a byte-array memory with a registered
// response, an i-cache contender and a shadow memory model. Covers DMEM_RETRY_LIMIT_EN when defined.
module tb_dcache_mem_port;
   import dcache_mem_port_pkg::*;

   localparam int LB       = LINE_WORDS * DATA_LEN;
   localparam int MEM_SIZE = 1 << ADDR_WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_mem_port_if bus();

   dcache_mem_port dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem    [MEM_SIZE];
   logic [7:0] shadow [MEM_SIZE];
   bit         mem_ready = 1'b0;
   int         stall_pct = 0;

   logic            icache_req = 1'b0;
   bit              ic_force = 1'b0;
   int              ic_rand_pct = 0;
   bit              ic_arm = 1'b0;
   logic [16:0]     ic_arm_addr = '0;
   bit              ic_fired = 1'b0;
   int              ic_hold = 0;

   typedef struct {
      logic [1:0]  sig;
      logic [16:0] addr;
   } beat_t;
   beat_t blog[$];
   int    dt_bad = 0;

   int n_checks = 0;
   int n_errors = 0;
   int n_xfer   = 0;
   logic [LB-1:0] last_refill = '0;

   task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Main memory: registers its response; the i-cache always wins when it asks.
   always @(posedge clk) begin
      logic [16:0] a;
      if (!mem_ready) begin
         for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'(i);
         mem_ready = 1'b1;
      end
      a = bus.mem_vis_addr;
      if (icache_req) begin
         bus.mem_status <= MEM_INST_FINISHED;
         bus.mem_data   <= $urandom;
      end else if (bus.mem_vis_signal != MEM_NOP && $urandom_range(99) >= stall_pct) begin
         bus.mem_status <= MEM_DATA_FINISHED;
         if (bus.mem_vis_signal == MEM_READ) begin
            bus.mem_data <= {mem[a], mem[a+17'd1], mem[a+17'd2], mem[a+17'd3]};
         end else begin
            mem[a]       = bus.written_data[31:24];
            mem[a+17'd1] = bus.written_data[23:16];
            mem[a+17'd2] = bus.written_data[15:8];
            mem[a+17'd3] = bus.written_data[7:0];
            bus.mem_data <= $urandom;
         end
      end else begin
         bus.mem_status <= MEM_RESTING;
         bus.mem_data   <= $urandom;
      end
   end

   always @(negedge clk) begin
      if (!rst && bus.mem_vis_signal != MEM_NOP) begin
         blog.push_back('{sig: bus.mem_vis_signal, addr: bus.mem_vis_addr});
         if (bus.data_type != FOUR_BYTE) dt_bad++;
      end
   end

   always @(negedge clk) begin
      if (ic_hold > 0) begin
         icache_req = 1'b1;
         ic_hold--;
      end else if (ic_arm && !ic_fired && bus.mem_vis_signal == MEM_READ && bus.mem_vis_addr == ic_arm_addr) begin
         icache_req = 1'b1;
         ic_hold    = 4;
         ic_fired   = 1'b1;
      end else begin
         icache_req = ic_force || (ic_rand_pct > 0 && $urandom_range(99) < ic_rand_pct);
      end
      if (!ic_arm) ic_fired = 1'b0;
   end

   function automatic logic [16:0] align(input logic [16:0] addr);
      return {addr[16:4], 4'b0000};
   endfunction

   function automatic logic [LB-1:0] shadow_line(input logic [16:0] base);
      logic [LB-1:0] l;
      logic [16:0]   a;
      for (int k = 0; k < LINE_WORDS; k++) begin
         a = base + 17'(4 * k);
         l[k*32 +: 32] = {shadow[a], shadow[a+17'd1], shadow[a+17'd2], shadow[a+17'd3]};
      end
      return l;
   endfunction

   function automatic logic [LB-1:0] mem_line(input logic [16:0] base);
      logic [LB-1:0] l;
      logic [16:0]   a;
      for (int k = 0; k < LINE_WORDS; k++) begin
         a = base + 17'(4 * k);
         l[k*32 +: 32] = {mem[a], mem[a+17'd1], mem[a+17'd2], mem[a+17'd3]};
      end
      return l;
   endfunction

   task automatic shadow_write_word(input logic [16:0] base, input int k, input logic [31:0] w);
      logic [16:0] a;
      a = base + 17'(4 * k);
      shadow[a]       = w[31:24];
      shadow[a+17'd1] = w[23:16];
      shadow[a+17'd2] = w[15:8];
      shadow[a+17'd3] = w[7:0];
   endtask

   // Retries repeat the same address back to back, so collapsed beats must be base, +4, +8, +12.
   task automatic check_beats(input int start, input logic [16:0] base, input logic [1:0] kind);
      int          n = 0;
      int          bad = 0;
      logic [16:0] prev = '0;
      for (int i = start; i < blog.size(); i++) begin
         if (blog[i].sig != kind) bad++;
         if (n == 0 || blog[i].addr != prev) begin
            if (n >= LINE_WORDS || blog[i].addr != base + 17'(4 * n)) bad++;
            n++;
            prev = blog[i].addr;
         end
      end
      check("beat_count", n, LINE_WORDS);
      check("beat_order", bad, 0);
      check("data_type", dt_bad, 0);
   endtask

   // Starts at a negedge with the DUT idle; returns at the negedge where resp_valid is seen.
   task automatic xfer(input bit wr, input logic [16:0] addr, input logic [LB-1:0] wd,
                       output int cycles, output int nbeats);
      int start;
      bit got = 1'b0;
      check("req_ready", bus.req_ready, 1);
      start          = blog.size();
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_write  = ~wr;
      bus.req_addr   = 17'($urandom);
      bus.req_wdata  = {$urandom, $urandom, $urandom, $urandom};
      cycles = 0;
      while (!got && cycles < 600) begin
         @(negedge clk);
         cycles++;
         if (bus.resp_valid) got = 1'b1;
      end
      check("resp_timeout", got, 1);
      nbeats = blog.size() - start;
      n_xfer++;
      $display("xfer %0d: %s addr=%05h beats=%0d cycles=%0d", n_xfer, wr ? "writeback" : "refill",
               addr, nbeats, cycles);
   endtask

   task automatic run_refill(input logic [16:0] addr);
      logic [16:0]   base;
      logic [LB-1:0] exp;
      int            cycles, nb, start;
      base  = align(addr);
      exp   = shadow_line(base);
      start = blog.size();
      xfer(1'b0, addr, {$urandom, $urandom, $urandom, $urandom}, cycles, nb);
      check("refill_data", bus.resp_rdata, exp);
      check_beats(start, base, MEM_READ);
      if (nb == LINE_WORDS) check("latency", cycles, 2 * LINE_WORDS + 1);
      last_refill = exp;
      @(negedge clk);
      check("resp_pulse", bus.resp_valid, 0);
      check("rdata_hold", bus.resp_rdata, exp);
   endtask

   task automatic run_wb(input logic [16:0] addr, input logic [LB-1:0] wd);
      logic [16:0] base;
      int          cycles, nb, start;
      base  = align(addr);
      start = blog.size();
      xfer(1'b1, addr, wd, cycles, nb);
      for (int k = 0; k < LINE_WORDS; k++) shadow_write_word(base, k, wd[k*32 +: 32]);
      check("wb_rdata_kept", bus.resp_rdata, last_refill);
      check("wb_mem", mem_line(base), shadow_line(base));
      check_beats(start, base, MEM_WRITE);
      if (nb == LINE_WORDS) check("latency", cycles, 2 * LINE_WORDS + 1);
      @(negedge clk);
      check("resp_pulse", bus.resp_valid, 0);
   endtask

   initial begin
      logic [LB-1:0] wd;
      logic [16:0]   a;
      int            cnt, cycles, nb, start;
      bit            found, saw;

      for (int i = 0; i < MEM_SIZE; i++) shadow[i] = 8'(i);
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_req_ready", bus.req_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_mem_sig", bus.mem_vis_signal, MEM_NOP);
      check("rst_mem_addr", bus.mem_vis_addr, 0);
      check("rst_wdata", bus.written_data, 0);
      check("rst_dtype", bus.data_type, 0);
      check("rst_rdata", bus.resp_rdata, 0);
`ifdef DMEM_RETRY_LIMIT_EN
      check("rst_err", bus.err, 0);
`endif

      run_refill(17'h00100);
      check("t1_word0", bus.resp_rdata[31:0], 32'h00010203);
      check("t1_word3", bus.resp_rdata[127:96], 32'h0C0D0E0F);

      wd = {32'h3, 32'h2, 32'h1, 32'hDEADBEEF};
      run_wb(17'h00200, wd);
      run_refill(17'h00200);
      check("t2_readback", bus.resp_rdata, wd);

      ic_arm_addr = 17'h00404;
      ic_arm      = 1'b1;
      start       = blog.size();
      run_refill(17'h00400);
      ic_arm = 1'b0;
      cnt = 0;
      for (int i = start; i < blog.size(); i++) if (blog[i].addr == 17'h00404) cnt++;
      check("ic_retry_beat1", cnt >= 2, 1);

      run_refill(17'h1FFF0);
      check("wrap_last_addr", blog[blog.size()-1].addr, 17'h1FFFC);
      run_wb(17'h1FFF7, {$urandom, $urandom, $urandom, $urandom});
      run_refill(17'h1FFF0);

      // Reset in the middle of a writeback, while beat 2 is on the bus.
      wd = {$urandom, $urandom, $urandom, $urandom};
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 17'h00300;
      bus.req_wdata = wd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (bus.mem_vis_signal == MEM_WRITE && bus.mem_vis_addr == 17'h00308) found = 1'b1;
      end
      check("rst_reach_beat2", found, 1);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_nop", bus.mem_vis_signal, MEM_NOP);
      check("midrst_busy", bus.busy, 0);
      saw = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (bus.resp_valid) saw = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.resp_valid) saw = 1'b1;
      end
      check("midrst_no_resp", saw, 0);
      shadow_write_word(17'h00300, 0, wd[31:0]);
      shadow_write_word(17'h00300, 1, wd[63:32]);
      last_refill = '0;
      run_refill(17'h00300);

      for (int i = 0; i < 30; i++) begin
         stall_pct   = $urandom_range(0, 30);
         ic_rand_pct = $urandom_range(0, 25);
         a = (i % 3 == 0) ? 17'($urandom) : 17'(17'h00800 + 17'($urandom_range(0, 255)));
         if ($urandom_range(1) == 1) run_wb(a, {$urandom, $urandom, $urandom, $urandom});
         else run_refill(a);
      end
      stall_pct   = 0;
      ic_rand_pct = 0;
      repeat (2) @(negedge clk);

`ifdef DMEM_RETRY_LIMIT_EN
      ic_force = 1'b1;
      @(negedge clk);
      start = blog.size();
      xfer(1'b0, 17'h00500, '0, cycles, nb);
      check("err_latency", cycles, 2 * (MAX_RETRY + 1) + 1);
      check("err_flag", bus.err, 1);
      check("err_beats", nb, MAX_RETRY + 1);
      ic_force = 1'b0;
      repeat (2) @(negedge clk);
      check("err_sticky", bus.err, 1);
      run_refill(17'h00500);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
